// File: rtl/inst_itf_demux_n.sv
// N-channel instruction-fetch demultiplexer: address-range decode, one outstanding
// fetch, error response for unmapped addresses and timeout abort of hung targets.
module inst_itf_demux_n #(
    parameter int unsigned                NUM_CH  = 3,
    parameter int unsigned                ADDR_W  = 32,
    parameter int unsigned                DATA_W  = 32,
    parameter logic [NUM_CH*ADDR_W-1:0]   CH_BASE = {32'h8000_0000, 32'h0001_0000, 32'h0000_0000},
    parameter logic [NUM_CH*ADDR_W-1:0]   CH_END  = {32'h8000_FFFF, 32'h0001_FFFF, 32'h0000_0FFF},
    parameter int unsigned                TIMEOUT = 256
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     inst_core_req_i,
    input  logic [ADDR_W-1:0]        inst_core_addr_i,
    output logic                     inst_core_ack_o,
    output logic [DATA_W-1:0]        inst_core_data_o,
    output logic                     inst_core_error_o,
    output logic [NUM_CH-1:0]        ch_req_o,
    output logic [ADDR_W-1:0]        ch_addr_o,
    input  logic [NUM_CH-1:0]        ch_ack_i,
    input  logic [NUM_CH-1:0]        ch_error_i,
    input  logic [NUM_CH*DATA_W-1:0] ch_data_i,
    output logic                     busy_o,
    output logic                     timeout_o
);

    localparam int unsigned SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_RESP
    } state_t;

    state_t              state_q, state_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [NUM_CH-1:0]   req_q, req_d;
    logic                ack_q, ack_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                err_q, err_d;
    logic                to_q, to_d;

    logic                hit;
    logic [SEL_W-1:0]    hit_idx;

    // Ascending scan that keeps the first hit gives lowest-index priority on overlap.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (!hit &&
                inst_core_addr_i >= CH_BASE[i*ADDR_W +: ADDR_W] &&
                inst_core_addr_i <= CH_END[i*ADDR_W +: ADDR_W]) begin
                hit     = 1'b1;
                hit_idx = SEL_W'(i);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        ack_d   = 1'b0;
        data_d  = '0;
        err_d   = 1'b0;
        to_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (inst_core_req_i) begin
                    if (hit) begin
                        addr_d  = inst_core_addr_i;
                        sel_d   = hit_idx;
                        req_d   = NUM_CH'(1) << hit_idx;
                        cnt_d   = '0;
                        state_d = S_BUSY;
                    end else begin
                        ack_d   = 1'b1;
                        err_d   = 1'b1;
                        state_d = S_RESP;
                    end
                end
            end
            S_BUSY: begin
                // Ack is tested first so it wins over a coincident timeout expiry.
                if (ch_ack_i[sel_q]) begin
                    ack_d   = 1'b1;
                    data_d  = ch_data_i[sel_q*DATA_W +: DATA_W];
                    err_d   = ch_error_i[sel_q];
                    req_d   = '0;
                    state_d = S_RESP;
                end else if (TIMEOUT != 0 && cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    ack_d   = 1'b1;
                    err_d   = 1'b1;
                    to_d    = 1'b1;
                    req_d   = '0;
                    state_d = S_RESP;
                end else if (TIMEOUT != 0) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                req_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            sel_q   <= '0;
            addr_q  <= '0;
            cnt_q   <= '0;
            req_q   <= '0;
            ack_q   <= 1'b0;
            data_q  <= '0;
            err_q   <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            ack_q   <= ack_d;
            data_q  <= data_d;
            err_q   <= err_d;
            to_q    <= to_d;
        end
    end

    assign inst_core_ack_o   = ack_q;
    assign inst_core_data_o  = data_q;
    assign inst_core_error_o = err_q;
    assign ch_req_o          = req_q;
    assign ch_addr_o         = addr_q;
    assign busy_o            = (state_q != S_IDLE);
    assign timeout_o         = to_q;

endmodule
